// File: rtl/dsp_result_drain.sv
// dsp_result_drain: round/shift/saturate stage plus a small result FIFO
// that drains DSP results to a ready/valid consumer without stalling it.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   res_valid, res_data  DSP result strobe and 2*WIDTH signed result
//   round_shift, sat_en  rounding shift amount and saturation enable
//   m_valid, m_ready     consumer handshake on the FIFO head
//   m_data, m_sat        head word and its clamp flag (0 when empty)
//   level                FIFO occupancy 0..DEPTH
//   overflow             sticky drop flag, cleared by clr_overflow
module dsp_result_drain #(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT_W   = 5,
   parameter int DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      res_valid,
   input  logic [2*WIDTH-1:0]        res_data,
   input  logic [SHIFT_W-1:0]        round_shift,
   input  logic                      sat_en,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [OUT_WIDTH-1:0]      m_data,
   output logic                      m_sat,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   input  logic                      clr_overflow
);

   localparam int DW = 2 * WIDTH;
   localparam int XW = DW + 1;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = OUT_WIDTH + 1;

   localparam logic signed [XW-1:0] ONE  = 1;
   localparam logic signed [XW-1:0] SMAX = (ONE <<< (OUT_WIDTH - 1)) - ONE;
   localparam logic signed [XW-1:0] SMIN = -(ONE <<< (OUT_WIDTH - 1));

   // stage 1: round, shift, saturate
   logic signed [XW-1:0]  ext;
   logic signed [XW-1:0]  rnd;
   logic signed [XW-1:0]  sum;
   logic signed [XW-1:0]  r;
   logic [OUT_WIDTH-1:0]  word;
   logic                  sat;

   logic                  s1_v;
   logic [OUT_WIDTH-1:0]  s1_word;
   logic                  s1_sat;

   // stage 2: FIFO
   logic [EW-1:0]         mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [EW-1:0]         head;
   logic                  full;
   logic                  pop;
   logic                  push;
   logic                  drop;

   // one extra bit keeps the rounding add from wrapping at the top of range
   always_comb begin
      ext = {res_data[DW-1], res_data};
      rnd = '0;
      if (round_shift != '0)
         rnd = ONE << (round_shift - 1'b1);
      sum = ext + rnd;
      r   = sum >>> round_shift;
      word = r[OUT_WIDTH-1:0];
      sat  = 1'b0;
      if (sat_en && (r > SMAX)) begin
         word = SMAX[OUT_WIDTH-1:0];
         sat  = 1'b1;
      end else if (sat_en && (r < SMIN)) begin
         word = SMIN[OUT_WIDTH-1:0];
         sat  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_word <= '0;
         s1_sat  <= 1'b0;
      end else begin
         s1_v <= res_valid;
         if (res_valid) begin
            s1_word <= word;
            s1_sat  <= sat;
         end
      end
   end

   assign m_valid = (level != '0);
   assign full    = (level == LW'(DEPTH));
   assign pop     = m_valid & m_ready;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push    = s1_v & (~full | pop);
   assign drop    = s1_v & full & ~pop;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {s1_sat, s1_word};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         // a drop in the same cycle as a clear keeps the flag set
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

   assign head   = mem[rd_ptr];
   assign m_data = m_valid ? head[OUT_WIDTH-1:0] : '0;
   assign m_sat  = m_valid & head[OUT_WIDTH];

endmodule

// File: tb/tb_dsp_result_drain.sv
// tb_dsp_result_drain: directed bench for dsp_result_drain
// (rounding, saturation, full/overflow, push+pop at full, reset).
module tb_dsp_result_drain;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        res_valid;
   logic [31:0] res_data;
   logic [4:0]  round_shift;
   logic        sat_en;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        m_sat;
   logic [2:0]  level;
   logic        overflow;
   logic        clr_overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dsp_result_drain #(
      .WIDTH(16), .OUT_WIDTH(16), .SHIFT_W(5), .DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .res_valid(res_valid),
      .res_data(res_data),
      .round_shift(round_shift),
      .sat_en(sat_en),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data),
      .m_sat(m_sat),
      .level(level),
      .overflow(overflow),
      .clr_overflow(clr_overflow)
   );

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [31:0] d, input logic [4:0] sh,
                         input logic se);
      res_valid   = 1'b1;
      res_data    = d;
      round_shift = sh;
      sat_en      = se;
      cyc();
   endtask

   task automatic idle();
      res_valid = 1'b0;
      res_data  = '0;
   endtask

   task automatic popchk(input string tag, input logic [15:0] d,
                         input logic s);
      chk({tag, "_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_data"}, 32'(m_data), 32'(d));
      chk({tag, "_sat"}, 32'(m_sat), 32'(s));
      m_ready = 1'b1;
      cyc();
      m_ready = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      res_valid    = 1'b0;
      res_data     = '0;
      round_shift  = '0;
      sat_en       = 1'b0;
      m_ready      = 1'b0;
      clr_overflow = 1'b0;
      cyc();
      cyc();
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      rst_n = 1'b1;
      cyc();

      // rounding
      strobe(32'h0000_0180, 5'd8, 1'b0);
      chk("lat_e0", 32'(m_valid), 32'd0);
      strobe(32'hFFFF_FE80, 5'd8, 1'b0);
      chk("lat_e1", 32'(m_valid), 32'd1);
      strobe(32'h0000_0005, 5'd0, 1'b0);
      strobe(32'h7FFF_FFFF, 5'd31, 1'b0);
      idle();
      cyc();
      chk("rnd_level", 32'(level), 32'd4);
      popchk("rnd0", 16'h0002, 1'b0);
      popchk("rnd1", 16'hFFFF, 1'b0);
      popchk("rnd2", 16'h0005, 1'b0);
      popchk("rnd3", 16'h0001, 1'b0);
      chk("rnd_empty", 32'(m_valid), 32'd0);

      // saturation
      strobe(32'h0010_0000, 5'd0, 1'b1);
      strobe(32'hFFF0_0000, 5'd0, 1'b1);
      strobe(32'h0010_0000, 5'd0, 1'b0);
      idle();
      cyc();
      chk("sat_level", 32'(level), 32'd3);
      popchk("sat_pos", 16'h7FFF, 1'b1);
      popchk("sat_neg", 16'h8000, 1'b1);
      popchk("sat_off", 16'h0000, 1'b0);
      chk("sat_empty_data", 32'(m_data), 32'd0);
      chk("sat_empty_sat", 32'(m_sat), 32'd0);

      // full and overflow
      for (int i = 1; i <= 5; i++)
         strobe(32'(i), 5'd0, 1'b0);
      idle();
      cyc();
      chk("full_level", 32'(level), 32'd4);
      chk("full_ovf", 32'(overflow), 32'd1);
      popchk("full0", 16'd1, 1'b0);
      popchk("full1", 16'd2, 1'b0);
      popchk("full2", 16'd3, 1'b0);
      popchk("full3", 16'd4, 1'b0);
      chk("full_drain", 32'(m_valid), 32'd0);
      chk("full_drain_lvl", 32'(level), 32'd0);

      clr_overflow = 1'b1;
      cyc();
      clr_overflow = 1'b0;
      chk("clr_alone", 32'(overflow), 32'd0);

      // push and pop together at full
      for (int i = 10; i <= 13; i++)
         strobe(32'(i), 5'd0, 1'b0);
      idle();
      cyc();
      chk("pp_full", 32'(level), 32'd4);
      strobe(32'd14, 5'd0, 1'b0);
      idle();
      chk("pp_head", 32'(m_data), 32'd10);
      m_ready = 1'b1;
      cyc();
      m_ready = 1'b0;
      chk("pp_level", 32'(level), 32'd4);
      chk("pp_ovf", 32'(overflow), 32'd0);
      popchk("pp0", 16'd11, 1'b0);
      popchk("pp1", 16'd12, 1'b0);
      popchk("pp2", 16'd13, 1'b0);
      popchk("pp3", 16'd14, 1'b0);
      chk("pp_empty", 32'(m_valid), 32'd0);

      // drop coinciding with clear
      for (int i = 20; i <= 23; i++)
         strobe(32'(i), 5'd0, 1'b0);
      strobe(32'd24, 5'd0, 1'b0);
      strobe(32'd25, 5'd0, 1'b0);
      idle();
      chk("drop_set", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      cyc();
      clr_overflow = 1'b0;
      chk("drop_vs_clr", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      cyc();
      clr_overflow = 1'b0;
      chk("clr_again", 32'(overflow), 32'd0);
      chk("drop_level", 32'(level), 32'd4);
      popchk("drop0", 16'd20, 1'b0);
      popchk("drop1", 16'd21, 1'b0);
      popchk("drop2", 16'd22, 1'b0);
      popchk("drop3", 16'd23, 1'b0);
      chk("drop_empty", 32'(m_valid), 32'd0);

      // reset mid-burst: three queued, one in stage 1
      strobe(32'd30, 5'd0, 1'b0);
      strobe(32'd31, 5'd0, 1'b0);
      strobe(32'd32, 5'd0, 1'b0);
      strobe(32'd33, 5'd0, 1'b0);
      idle();
      chk("mid_level", 32'(level), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(m_valid), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_data", 32'(m_data), 32'd0);
      chk("mid_rst_sat", 32'(m_sat), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      chk("mid_discard", 32'(level), 32'd0);
      strobe(32'd40, 5'd0, 1'b0);
      idle();
      cyc();
      chk("post_level", 32'(level), 32'd1);
      popchk("post0", 16'd40, 1'b0);
      chk("post_empty", 32'(m_valid), 32'd0);
      chk("post_lvl0", 32'(level), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dsp_result_drain.md
# dsp_result_drain

Downstream drain stage for the DSP multiply/MAC datapath. It captures each finished result, using the DSP's `compare_res` strobe as the valid qualifier, and rounds and shifts it to a narrower output word with optional saturation. Results are buffered in a small FIFO and handed to the consumer over a ready/valid interface, so the DSP can issue back-to-back results without stalling. The block never back-pressures the DSP: excess results are dropped and flagged.

## Interface
- `WIDTH`, 16, DSP operand width; the result input is 2*WIDTH bits.
- `OUT_WIDTH`, 16, output word width; 1 ≤ OUT_WIDTH ≤ 2*WIDTH.
- `SHIFT_W`, 5, width of `round_shift`; must cover shifts 0..2*WIDTH-1.
- `DEPTH`, 4, number of FIFO entries; must be a power of two, ≥ 2.
- `clk`, input, 1, sole clock; all logic on the rising edge.
- `rst_n`, input, 1, reset: asynchronous, active-low.
- `res_valid`, input, 1, result strobe; tied to DSP `compare_res`.
- `res_data`, input, 2*WIDTH, signed result; tied to DSP `out`.
- `round_shift`, input, SHIFT_W, arithmetic right-shift amount; sampled together with `res_valid`.
- `sat_en`, input, 1, enables saturation; sampled together with `res_valid`.
- `m_valid`, output, 1, FIFO head is valid.
- `m_ready`, input, 1, consumer accepts the head.
- `m_data`, output, OUT_WIDTH, signed head word; 0 when `m_valid` = 0.
- `m_sat`, output, 1, head word was clamped; 0 when `m_valid` = 0.
- `level`, output, $clog2(DEPTH)+1, current FIFO occupancy, 0..DEPTH.
- `overflow`, output, 1, sticky flag: a result was dropped.
- `clr_overflow`, input, 1, synchronous clear of `overflow`.

## Operation
- **Stage 1 (round).** On an edge where `res_valid` = 1, compute r = (sext(`res_data`) + (`round_shift` == 0 ? 0 : 1 << (`round_shift` - 1))) >>> `round_shift`.
  - Use a 2*WIDTH+1-bit signed intermediate so the rounding add never wraps.
  - Rounding is round-half-up toward +inf.
- **Stage 1 (saturate).** Applies only when `sat_en` = 1 and r is outside the signed OUT_WIDTH range.
  - Clamp to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1), and set sat = 1.
  - Otherwise the word is the low OUT_WIDTH bits of r, with sat = 0.
- The word and sat flag are registered into a stage-1 holding register with its own valid bit (`s1_v`). `s1_v` follows `res_valid` every cycle.
- **Stage 2 (FIFO write).** When `s1_v` = 1, push {sat, word} into the FIFO.
  - Use circular read/write pointers of width $clog2(DEPTH), wrapping DEPTH-1 → 0.
- **Pop.** A pop occurs when `m_valid` && `m_ready`.
- **Full.** If `level` == DEPTH and there is no pop this cycle, the push is dropped and `overflow` is set.
  - If a pop coincides, the push is accepted and `level` stays at DEPTH.
- **Empty.** `m_valid` = 0; `m_ready` is ignored.
  - A push into an empty FIFO is not bypassed; it becomes visible on the next cycle.
- **`level` update.**
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
- **`overflow`.** Cleared by `clr_overflow`. If a drop occurs in the same cycle as `clr_overflow`, the set wins.
- **Reset.** Asserting `rst_n` low at any time, including mid-burst, clears all state at once:
  - Pointers and `level` go to 0.
  - `s1_v` and `overflow` go to 0.
  - `m_valid` = 0, `m_data` = 0, `m_sat` = 0.
  - Any in-flight stage-1 result is discarded. FIFO storage needs no reset.

## Timing
- Latency is 2 edges.
  - `res_valid` high at edge E0 → stage-1 register loaded at E0.
  - FIFO written at E1; if the FIFO was empty, `m_valid` is high after E1.
- Throughput: one result per cycle in, one word per cycle out.
- `m_data` and `m_sat` are driven combinationally from the registered FIFO head; there is no combinational path from `res_*` to `m_*`.
- `m_valid` must stay high, with `m_data` stable, until the word is popped.

## Test plan
- **Rounding.** WIDTH=16, OUT_WIDTH=16. Input `res_data`=0x00000180 with `round_shift`=8, then 0xFFFFFE80 with `round_shift`=8, then 0x00000005 with `round_shift`=0. Expect `m_data` = 0x0002, 0xFFFF, 0x0005 in order; `m_sat` = 0 for all; first word visible 2 cycles after the first strobe.
- **Saturation.** Input `res_data`=0x00100000, `round_shift`=0, `sat_en`=1 → `m_data`=0x7FFF, `m_sat`=1. Input 0xFFF00000 → 0x8000, `m_sat`=1. With `sat_en`=0, input 0x00100000 → 0x0000, `m_sat`=0.
- **Full and overflow.** DEPTH=4, hold `m_ready`=0, issue 5 back-to-back strobes with values 1..5. Expect `level`=4 and `overflow`=1 one edge after the 5th write attempt. Then raise `m_ready`: pops return 1, 2, 3, 4 in order, and `m_valid` drops after the 4th.
- **Simultaneous push and pop at full.** With `level`=4 and `m_ready`=1 as a 5th result lands: `level` stays 4, `overflow` stays 0, and after 4 more pops the new value is delivered.
- **Overflow clear.** Assert `clr_overflow` alone → `overflow`=0. Assert `clr_overflow` in the same cycle as a drop → `overflow` stays 1.
- **Reset mid-burst.** With 3 entries queued and one in stage 1, pulse `rst_n` low. Outputs immediately go to `m_valid`=0, `level`=0, `m_data`=0. After release, the next strobe yields a single entry carrying the new value.
